// File: rtl/nn_fixed_pkg.sv
// Shared Q4.12 fixed-point types, limits and the MAC neuron FSM state encoding.
package nn_fixed_pkg;

   localparam int unsigned FRAC_BITS = 12;

   typedef logic signed [15:0] q4_12_t;

   localparam q4_12_t Q_MAX = 16'sh7FFF;
   localparam q4_12_t Q_MIN = 16'sh8000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_FINISH,
      ST_OUTPUT
   } mac_state_e;

endpackage

// File: rtl/neuron_mac_q_round_sat.sv
// q_round_sat: combinational round, shift and clamp of a Q.24 accumulator to Q4.12.
// NEURON_MAC_ROUND_EN selects round-half-up; otherwise truncation toward -inf.
module q_round_sat
   import nn_fixed_pkg::*;
#(
   parameter int unsigned ACC_W = 40
) (
   input  logic signed [ACC_W-1:0] acc_i,
   output q4_12_t                  z_o,
   output logic                    sat_o
);

`ifdef NEURON_MAC_ROUND_EN
   localparam logic signed [ACC_W:0] RND =
      {{(ACC_W + 1 - FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};
`else
   localparam logic signed [ACC_W:0] RND = '0;
`endif

   localparam logic signed [ACC_W:0] HI = (ACC_W + 1)'(Q_MAX);
   localparam logic signed [ACC_W:0] LO = (ACC_W + 1)'(Q_MIN);

   logic signed [ACC_W:0] sum_w;
   logic signed [ACC_W:0] shift_w;

   // One guard bit keeps the rounding add from wrapping at the accumulator edge.
   always_comb begin
      sum_w   = $signed({acc_i[ACC_W-1], acc_i}) + RND;
      shift_w = sum_w >>> FRAC_BITS;
      z_o     = shift_w[15:0];
      sat_o   = 1'b0;
      if (shift_w > HI) begin
         z_o   = Q_MAX;
         sat_o = 1'b1;
      end else if (shift_w < LO) begin
         z_o   = Q_MIN;
         sat_o = 1'b1;
      end
   end

endmodule

// File: rtl/neuron_mac.sv
// Sequential multiply-accumulate neuron: N Q4.12 x/w pairs plus bias -> Q4.12 z.
// Output rounding mode follows NEURON_MAC_ROUND_EN (see q_round_sat).
module neuron_mac
   import nn_fixed_pkg::*;
#(
   parameter int unsigned N_INPUTS = 8,
   parameter int unsigned ACC_W    = 40
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   start,
   input  q4_12_t bias,
   input  logic   in_valid,
   output logic   in_ready,
   input  q4_12_t x_in,
   input  q4_12_t w_in,
   output logic   out_valid,
   input  logic   out_ready,
   output q4_12_t z,
   output logic   sat,
   output logic   busy
);

   localparam int unsigned      CNT_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

   mac_state_e               state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   q4_12_t                   z_q, z_d;
   logic                     sat_q, sat_d;

   logic signed [31:0]       prod;
   q4_12_t                   rs_z;
   logic                     rs_sat;

   assign prod = x_in * w_in;

   q_round_sat #(
      .ACC_W (ACC_W)
   ) u_round_sat (
      .acc_i (acc_q),
      .z_o   (rs_z),
      .sat_o (rs_sat)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      z_d     = z_q;
      sat_d   = sat_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               acc_d   = ACC_W'(bias) <<< FRAC_BITS;
               cnt_d   = '0;
               state_d = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (in_valid) begin
               acc_d = acc_q + ACC_W'(prod);
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_FINISH;
               end
            end
         end
         ST_FINISH: begin
            z_d     = rs_z;
            sat_d   = rs_sat;
            state_d = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         z_q     <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
         sat_q   <= sat_d;
      end
   end

   assign in_ready  = (state_q == ST_ACCUM);
   assign out_valid = (state_q == ST_OUTPUT);
   assign busy      = (state_q != ST_IDLE);
   assign z         = z_q;
   assign sat       = sat_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Randomized self-checking bench for neuron_mac against an arithmetic reference model.
module tb_neuron_mac;

   localparam int unsigned N = 4;

`ifdef NEURON_MAC_ROUND_EN
   localparam longint RND = 2048;
`else
   localparam longint RND = 0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic signed [15:0] bias = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic signed [15:0] x_in = '0;
   logic signed [15:0] w_in = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic signed [15:0] z;
   logic              sat;
   logic              busy;

   int checks = 0;
   int errors = 0;

   logic signed [15:0] xs [N];
   logic signed [15:0] ws [N];

   always #5 clk = ~clk;

   neuron_mac #(
      .N_INPUTS (N),
      .ACC_W    (40)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bias      (bias),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .w_in      (w_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .sat       (sat),
      .busy      (busy)
   );

   task automatic check_eq(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Exact sum in Q.24, then floor division by 2^12 and clamp to 16-bit signed.
   function automatic void model(input longint b, output longint ez, output longint esat);
      longint s, r;
      s = b * 4096;
      for (int i = 0; i < N; i++) s += longint'(xs[i]) * longint'(ws[i]);
      s += RND;
      r = s / 4096;
      if ((s % 4096 != 0) && (s < 0)) r -= 1;
      esat = 0;
      ez   = r;
      if (r > 32767) begin
         ez = 32767; esat = 1;
      end else if (r < -32768) begin
         ez = -32768; esat = 1;
      end
   endfunction

   task automatic run_eval(input logic signed [15:0] b, input bit gaps, input int stall,
                           input bit chk_lat);
      int     n, i, guard;
      bit     took;
      longint ez, es;
      guard = 0;
      while (busy && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      check_eq("idle_before_start", longint'(busy), 0);
      bias      = b;
      start     = 1'b1;
      in_valid  = 1'b0;
      out_ready = (stall == 0);
      @(posedge clk); #1;
      start = 1'b0;
      bias  = 16'($urandom);
      n     = 1;
      check_eq("in_ready_accum", longint'(in_ready), 1);
      i = 0;
      while (i < N && n < 200) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0; x_in = 16'($urandom); w_in = 16'($urandom);
         end else begin
            in_valid = 1'b1; x_in = xs[i]; w_in = ws[i];
         end
         took = in_valid && in_ready;
         @(posedge clk); #1; n++;
         if (took) i++;
      end
      in_valid = 1'b1; x_in = 16'($urandom); w_in = 16'($urandom);
      while (!out_valid && n < 200) begin
         check_eq("in_ready_low", longint'(in_ready), 0);
         @(posedge clk); #1; n++;
      end
      check_eq("out_valid", longint'(out_valid), 1);
      if (chk_lat) check_eq("latency", n, 6);
      model(longint'(b), ez, es);
      check_eq("z", longint'(z), ez);
      check_eq("sat", longint'(sat), es);
      for (int k = 0; k < stall; k++) begin
         start = (k == 1);
         @(posedge clk); #1;
         check_eq("stall_valid", longint'(out_valid), 1);
         check_eq("stall_z", longint'(z), ez);
         check_eq("stall_in_ready", longint'(in_ready), 0);
      end
      start     = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_eq("valid_drop", longint'(out_valid), 0);
      check_eq("busy_drop", longint'(busy), 0);
   endtask

   task automatic fill(input logic signed [15:0] xv, input logic signed [15:0] wv);
      for (int i = 0; i < N; i++) begin
         xs[i] = xv; ws[i] = wv;
      end
   endtask

   task automatic reset_mid_eval();
      fill(16'sh1000, 16'sh1000);
      start = 1'b1; bias = 16'sh0100;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; x_in = xs[i]; w_in = ws[i];
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_in_ready", longint'(in_ready), 0);
      check_eq("rst_out_valid", longint'(out_valid), 0);
      check_eq("rst_z", longint'(z), 0);
      check_eq("rst_sat", longint'(sat), 0);
      check_eq("rst_busy", longint'(busy), 0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      fill(16'sh0000, 16'sh0000);
      run_eval(16'shF800, 1'b0, 0, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic signed [15:0] t;
      #12;
      check_eq("reset_in_ready", longint'(in_ready), 0);
      check_eq("reset_out_valid", longint'(out_valid), 0);
      check_eq("reset_z", longint'(z), 0);
      check_eq("reset_sat", longint'(sat), 0);
      check_eq("reset_busy", longint'(busy), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      fill(16'sh1000, 16'sh1000);
      run_eval(16'sh0000, 1'b0, 0, 1'b1);
      check_eq("unity_z_hex", longint'(z), 16384);

      fill(16'sh7000, 16'sh7000);
      run_eval(16'sh0000, 1'b0, 0, 1'b1);
      fill(16'sh7000, 16'sh9000);
      run_eval(16'sh0000, 1'b0, 0, 1'b1);

      fill(16'sh0000, 16'sh0000);
      xs[0] = 16'sh0001; ws[0] = 16'sh0800;
      run_eval(16'sh0000, 1'b0, 0, 1'b1);

      for (int i = 0; i < N; i++) begin
         xs[i] = 16'($urandom) >>> 4; ws[i] = 16'($urandom) >>> 4;
      end
      run_eval(16'($urandom) >>> 3, 1'b1, 5, 1'b0);

      reset_mid_eval();

      for (int r = 0; r < 30; r++) begin
         bit g;
         for (int i = 0; i < N; i++) begin
            t = 16'($urandom); xs[i] = t >>> $urandom_range(0, 8);
            t = 16'($urandom); ws[i] = t >>> $urandom_range(0, 8);
         end
         t = 16'($urandom);
         g = 1'($urandom_range(0, 1));
         run_eval(t >>> $urandom_range(0, 6), g, int'($urandom_range(0, 3)), !g);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Upstream stage of the activation unit: a sequential multiply-accumulate neuron that streams N input/weight pairs in Q4.12 and produces one pre-activation value z in Q4.12. The sigmoid stage consumes z directly as its `x`. It adds a bias, then rounds and saturates the wide accumulator to 16 bits. Valid/ready handshakes are used on both sides so that the block can sit between an input buffer and the activation stage.

## Interface
Parameters:
- `N_INPUTS`, 8, number of x/w pairs per neuron evaluation (≥1)
- `ACC_W`, 40, signed accumulator width (≥32 + clog2(N_INPUTS) + 1)

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin new evaluation; sampled only in IDLE
- `bias`  in  16  signed Q4.12 bias; sampled with `start`
- `in_valid`  in  1  x/w pair present
- `in_ready`  out  1  block accepts pair
- `x_in`  in  16  signed Q4.12 input
- `w_in`  in  16  signed Q4.12 weight
- `out_valid`  out  1  z valid
- `out_ready`  in  1  downstream accepts z
- `z`  out  16  signed Q4.12 result, to sigmoid `x`
- `sat`  out  1  z was clamped; qualified by `out_valid`
- `busy`  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, ACCUM, FINISH, OUTPUT.
- IDLE → ACCUM on `start`:
  - `acc` ← sign-extended `bias` << 12 (Q.24 alignment)
  - `cnt` ← 0
- ACCUM:
  - `in_ready` = 1.
  - On each `in_valid && in_ready`: `acc` += sign-extended 32-bit product `x_in*w_in` (Q8.24); `cnt`++.
  - On the handshake with `cnt == N_INPUTS-1` → FINISH.
  - `in_valid` low: hold state, no accumulation.
- FINISH (one cycle):
  - r = (`acc` + rounding term) >>> 12 (arithmetic shift).
  - Clamp r to [-32768, 32767]; `sat` = 1 if clamped.
  - Register the result into `z` → OUTPUT.
- OUTPUT:
  - `out_valid` = 1; `z` and `sat` held stable.
  - On `out_ready` → IDLE and `out_valid` drops the next cycle.
  - No skid buffer.
- `start` outside IDLE is ignored (no queuing).
- `in_ready` = 0 outside ACCUM; pairs offered there are not consumed.
- The accumulator never wraps inside ACC_W at the legal minimum width; saturation happens only at output.
- Reset values: `in_ready` 0, `out_valid` 0, `z` 0, `sat` 0, `busy` 0, state IDLE, `acc` 0, `cnt` 0.
- Reset asserted mid-operation aborts the evaluation immediately; partial sums are discarded.

## Timing
- `start` sampled at edge 0 → `in_ready` high from cycle 1.
- With back-to-back pairs, the last pair is accepted at edge N.
- FINISH occupies cycle N+1; `out_valid` is high from cycle N+2.
- Minimum start-to-start period: N+3 cycles with `out_ready` tied high.
- Throughput: one pair per cycle in ACCUM.
- Output latency from last pair: 2 cycles.
- `out_valid` and `z` are registered outputs.
- `in_ready` is a decode of registered state; it has no combinational path from `in_valid`.

## Configuration
- `NEURON_MAC_ROUND_EN` defined: rounding term = 2^11 (round half up toward +∞).
- Not defined: rounding term = 0 (truncation toward −∞).
- Saturation is unaffected by the macro.

## Structure
- Shared package `nn_fixed_pkg`:
  - `FRAC_BITS` = 12
  - `q4_12_t` (logic signed [15:0])
  - `Q_MAX` = 16'sh7FFF, `Q_MIN` = 16'sh8000
  - FSM state enum `mac_state_e`
- One sub-module, `q_round_sat`: a combinational round/shift/clamp from ACC_W to Q4.12 plus the `sat` flag. It is reusable by later layers.

## Test plan
- N_INPUTS=4, bias 0, four pairs x=0x1000, w=0x1000 back-to-back → z=0x4000, sat=0, `out_valid` 6 cycles after `start`.
- Four pairs x=0x7000, w=0x7000 → z=0x7FFF, sat=1; repeat with w=0x9000 → z=0x8000, sat=1.
- Pairs {x=0x0001, w=0x0800}, then three zero pairs, bias 0 → z=0x0001 with `NEURON_MAC_ROUND_EN`, z=0x0000 without.
- Gaps in `in_valid` plus `out_ready` held low for 5 cycles with `start` pulsed during OUTPUT → no extra accumulation, z stable, `out_valid` held, `start` ignored.
- `rst_n` pulsed low after 2 of 4 pairs → all outputs 0 asynchronously; a new evaluation with bias=0xF800 and zero inputs → z=0xF800.
